uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of the SoC's uart_tx.
- Oversamples i_uart_rx on the system clock and samples each bit at mid-bit.
- Presents each received byte on a valid/ready output port to the SoC bus or FIFO.
- Flags stop-bit framing errors and unaccepted-byte overruns.

---
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// valid/ready output register that flags framing errors and overruns.
module uart_rx #(
  parameter int clk_freq_hz = 100000000,
  parameter int baud_rate   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CLKS_PER_BIT = clk_freq_hz / baud_rate;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
      $error("uart_rx: clk_freq_hz/baud_rate must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t          state, state_next;
  logic            sync1, rx_s;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shift, shift_next;
  logic            byte_done;
  logic            frame_bad;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    byte_done    = 1'b0;
    frame_bad    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            state_next   = DATA;
            cnt_next     = FULL_LOAD;
            bit_idx_next = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_next = {rx_s, shift[7:1]};
          cnt_next   = FULL_LOAD;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      STOP: begin
        // Returning to IDLE at mid-stop-bit leaves half a bit to catch the next start edge.
        if (cnt == '0) begin
          if (rx_s) begin
            byte_done  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1       <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      sync1       <= i_uart_rx;
      rx_s        <= sync1;
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shift       <= shift_next;
      o_frame_err <= frame_bad;
      o_overrun   <= 1'b0;
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      // A consuming edge frees the slot, so a byte finishing on that same edge is kept.
      if (byte_done) begin
        if (!o_valid || i_ready) begin
          o_data  <= shift;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 10 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CLK_HZ = 1000000;
   localparam int BAUD   = 100000;
   localparam int CPB    = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;

   uart_rx #(
      .clk_freq_hz(CLK_HZ),
      .baud_rate  (BAUD)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_uart_rx  (rx),
      .o_data     (data),
      .o_valid    (valid),
      .i_ready    (ready),
      .o_frame_err(frame_err),
      .o_overrun  (overrun)
   );

   // free-running clock, 10 ns period
   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   int         checks = 0;
   int         errors = 0;
   int         vcyc = 0;
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   logic [7:0] acc_data[$];
   int         acc_cycle[$];

   // observer: samples outputs on the falling edge and logs every accepted byte
   always @(negedge clk) begin
      if (valid === 1'b1) vcyc <= vcyc + 1;
      if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
      if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
      if (valid === 1'b1 && ready === 1'b1) begin
         acc_data.push_back(data);
         acc_cycle.push_back(cycle);
      end
   end

   int base_v, base_fe, base_ov, base_acc;
   int start_cycle;
   int lat;
   int lat_meas;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic snap();
      base_v   = vcyc;
      base_fe  = fe_cnt;
      base_ov  = ov_cnt;
      base_acc = acc_data.size();
   endtask

   task automatic driveBit(input logic v);
      rx = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // one 8N1 frame, LSB first; stop_bit=0 produces a framing error
   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
      start_cycle = cycle + 1;
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(b[i]);
      driveBit(stop_bit);
   endtask

   function automatic logic [7:0] accAt(input int idx);
      if (idx < acc_data.size()) return acc_data[idx];
      return 8'hxx;
   endfunction

   function automatic int cycAt(input int idx);
      if (idx < acc_cycle.size()) return acc_cycle[idx];
      return -1000;
   endfunction

   initial begin
      // reset values
      rst_n = 1'b0;
      rx    = 1'b1;
      ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_valid", valid, 0);
      checkOutput("reset_data", data, 8'h00);
      checkOutput("reset_frame_err", frame_err, 0);
      checkOutput("reset_overrun", overrun, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idleCycles(20);

      // single byte with latency check
      snap();
      applyStimulus(8'hA5, 1'b1);
      idleCycles(10);
      checkOutput("a5_count", acc_data.size() - base_acc, 1);
      checkOutput("a5_data", accAt(base_acc), 8'hA5);
      lat = cycAt(base_acc) - start_cycle;
      checkOutput("a5_latency_97_to_99", (lat >= 97 && lat <= 99), 1);
      checkOutput("a5_valid_cycles", vcyc - base_v, 1);
      checkOutput("a5_frame_err", fe_cnt - base_fe, 0);
      checkOutput("a5_overrun", ov_cnt - base_ov, 0);
      lat_meas = (lat >= 90 && lat <= 110) ? lat : 97;

      // back-to-back frames with no idle gap
      snap();
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'hFF, 1'b1);
      applyStimulus(8'h55, 1'b1);
      idleCycles(10);
      checkOutput("b2b_count", acc_data.size() - base_acc, 3);
      checkOutput("b2b_data0", accAt(base_acc), 8'h00);
      checkOutput("b2b_data1", accAt(base_acc + 1), 8'hFF);
      checkOutput("b2b_data2", accAt(base_acc + 2), 8'h55);
      checkOutput("b2b_gap01", cycAt(base_acc + 1) - cycAt(base_acc), 100);
      checkOutput("b2b_gap12", cycAt(base_acc + 2) - cycAt(base_acc + 1), 100);
      checkOutput("b2b_flags", (fe_cnt - base_fe) + (ov_cnt - base_ov), 0);

      // short glitch must be rejected
      snap();
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      idleCycles(40);
      checkOutput("glitch_valid_cycles", vcyc - base_v, 0);
      checkOutput("glitch_flags", (fe_cnt - base_fe) + (ov_cnt - base_ov), 0);

      // framing error followed by a held-low break
      snap();
      applyStimulus(8'h3C, 1'b0);
      rx = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      idleCycles(20);
      checkOutput("break_frame_err_once", fe_cnt - base_fe, 1);
      checkOutput("break_no_valid", vcyc - base_v, 0);
      applyStimulus(8'h81, 1'b1);
      idleCycles(10);
      checkOutput("after_break_data", accAt(base_acc), 8'h81);
      checkOutput("after_break_count", acc_data.size() - base_acc, 1);
      checkOutput("after_break_fe_total", fe_cnt - base_fe, 1);

      // backpressure and overrun
      snap();
      ready = 1'b0;
      applyStimulus(8'h12, 1'b1);
      applyStimulus(8'h34, 1'b1);
      idleCycles(10);
      @(negedge clk);
      checkOutput("bp_valid_held", valid, 1);
      checkOutput("bp_data_held", data, 8'h12);
      checkOutput("bp_overrun_once", ov_cnt - base_ov, 1);
      checkOutput("bp_none_accepted", acc_data.size() - base_acc, 0);
      @(posedge clk); #1;
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      @(negedge clk);
      checkOutput("bp_valid_cleared", valid, 0);
      checkOutput("bp_accepted_data", accAt(base_acc), 8'h12);

      // consume on the very edge a new byte completes
      applyStimulus(8'h12, 1'b1);
      idleCycles(5);
      @(negedge clk);
      checkOutput("sim_pre_data", data, 8'h12);
      @(posedge clk); #1;
      snap();
      fork
         applyStimulus(8'h77, 1'b1);
         begin
            repeat (lat_meas) @(posedge clk);
            #1;
            ready = 1'b1;
            @(posedge clk);
            #1;
            ready = 1'b0;
         end
      join
      idleCycles(5);
      @(negedge clk);
      checkOutput("sim_valid", valid, 1);
      checkOutput("sim_data", data, 8'h77);
      checkOutput("sim_overrun", ov_cnt - base_ov, 0);
      checkOutput("sim_old_accepted", accAt(base_acc), 8'h12);
      @(posedge clk); #1;
      ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("sim_new_accepted", accAt(base_acc + 1), 8'h77);
      checkOutput("sim_valid_cleared", valid, 0);

      // reset in the middle of data bit 4 of 0xC3
      @(posedge clk); #1;
      snap();
      driveBit(1'b0);
      driveBit(1'b1);
      driveBit(1'b1);
      driveBit(1'b0);
      driveBit(1'b0);
      rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_mid_valid", valid, 0);
      checkOutput("rst_mid_data", data, 8'h00);
      checkOutput("rst_mid_frame_err", frame_err, 0);
      checkOutput("rst_mid_overrun", overrun, 0);
      rst_n = 1'b1;
      rx = 1'b1;
      @(posedge clk); #1;
      idleCycles(150);
      checkOutput("rst_mid_no_pulses", (vcyc - base_v) + (fe_cnt - base_fe) + (ov_cnt - base_ov), 0);
      applyStimulus(8'h5A, 1'b1);
      idleCycles(10);
      checkOutput("rst_after_data", accAt(base_acc), 8'h5A);
      checkOutput("rst_after_count", acc_data.size() - base_acc, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
